// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button conditioner.
// Each channel has a synchroniser, a tick-qualified stability counter and
// registered level / press / release outputs; one prescaler is shared.
// Optional hold-to-repeat is built when DEBOUNCE_REPEAT_EN is defined.
module debounce_bank #(
  parameter int CHANNELS     = 3,
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STB_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DLY = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RAT = HOLD_W'(REPEAT_RATE - 1);
`endif

  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_r;

  // Shared prescaler: wraps at TICK_DIV-1 and strobes tick the cycle after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      tick_r <= (div_cnt_r == DIV_LAST);
    end
  end

  assign tick = tick_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [STB_W-1:0]       stb_cnt_r;
    logic [STB_W-1:0]       stb_cnt_s;
    logic                   accept_s;
    logic                   repeat_s;
    logic                   level_r;
    logic                   press_r;
    logic                   release_r;

    // Synchroniser chain for the asynchronous button input.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Stability qualification: a new level must differ on consecutive ticks.
    always_comb begin
      stb_cnt_s = stb_cnt_r;
      accept_s  = 1'b0;
      if (tick_r) begin
        if (sync_s == level_r) begin
          stb_cnt_s = '0;
        end else if (stb_cnt_r == STB_LAST) begin
          stb_cnt_s = '0;
          accept_s  = 1'b1;
        end else begin
          stb_cnt_s = stb_cnt_r + STB_W'(1);
        end
      end else begin
        stb_cnt_s = stb_cnt_r;
      end
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic              rep_r;
    logic              rep_s;

    // Hold-to-repeat: first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE.
    always_comb begin
      hold_s   = hold_r;
      rep_s    = rep_r;
      repeat_s = 1'b0;
      if (!level_r || accept_s) begin
        hold_s = '0;
        rep_s  = 1'b0;
      end else if (tick_r) begin
        if (!rep_r) begin
          if (hold_r == HOLD_DLY) begin
            hold_s   = '0;
            rep_s    = 1'b1;
            repeat_s = 1'b1;
          end else begin
            hold_s = hold_r + HOLD_W'(1);
          end
        end else begin
          if (hold_r == HOLD_RAT) begin
            hold_s   = '0;
            repeat_s = 1'b1;
          end else begin
            hold_s = hold_r + HOLD_W'(1);
          end
        end
      end else begin
        hold_s = hold_r;
      end
    end

    // Hold counter state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_r <= '0;
        rep_r  <= 1'b0;
      end else begin
        hold_r <= hold_s;
        rep_r  <= rep_s;
      end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Registered level and single-cycle pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stb_cnt_r <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        stb_cnt_r <= stb_cnt_s;
        if (accept_s) begin
          level_r   <= sync_s;
          press_r   <= sync_s;
          release_r <= ~sync_s;
        end else begin
          level_r   <= level_r;
          press_r   <= repeat_s;
          release_r <= 1'b0;
        end
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;
  end

endmodule
